sdram_port_arbiter: RTL

- Shares the single `sdram_top` user port between two burst clients (client 0, client 1). Each client may request a read or a write burst.
- Issues `sdram_wr_req`/`sdram_rd_req`, counts per-word acks, routes ack/data to the granted client, and signals completion.
- Sits between the application logic and `sdram_top` in the `clk_100m` domain; replaces ad-hoc per-design request FSMs.

---
 rtl/sdram_port_arbiter.sv | 289 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/sdram_port_arbiter.sv
// Two-client round-robin burst arbiter in front of the sdram_top user port.
// Optional XFER watchdog is compiled in when ARB_TIMEOUT_EN is defined.
module sdram_port_arbiter #(
  parameter int ADDR_W         = 24,
  parameter int DATA_W         = 16,
  parameter int LEN_W          = 10,
  parameter int MAX_LEN        = 512,
  parameter int TIMEOUT_CYCLES = 4096
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              c0_req,
  input  logic              c0_wr,
  input  logic [ADDR_W-1:0] c0_addr,
  input  logic [LEN_W-1:0]  c0_len,
  input  logic [DATA_W-1:0] c0_wdata,
  output logic              c0_gnt,
  output logic              c0_wr_ack,
  output logic              c0_rd_ack,
  output logic              c0_done,
  input  logic              c1_req,
  input  logic              c1_wr,
  input  logic [ADDR_W-1:0] c1_addr,
  input  logic [LEN_W-1:0]  c1_len,
  input  logic [DATA_W-1:0] c1_wdata,
  output logic              c1_gnt,
  output logic              c1_wr_ack,
  output logic              c1_rd_ack,
  output logic              c1_done,
  output logic [DATA_W-1:0] rdata,
  output logic              err,
  input  logic              sdram_init_done,
  output logic              sdram_wr_req,
  output logic              sdram_rd_req,
  input  logic              sdram_wr_ack,
  input  logic              sdram_rd_ack,
  input  logic [DATA_W-1:0] sys_data_out,
  output logic [ADDR_W-1:0] sys_wraddr,
  output logic [ADDR_W-1:0] sys_rdaddr,
  output logic [LEN_W-1:0]  sdwr_byte,
  output logic [LEN_W-1:0]  sdrd_byte,
  output logic [DATA_W-1:0] sys_data_in
);

  typedef enum logic [1:0] {
    S_INIT = 2'd0,
    S_IDLE = 2'd1,
    S_XFER = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam logic [LEN_W-1:0]  MAX_LEN_V = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0]  LEN_ZERO  = {LEN_W{1'b0}};
  localparam logic [LEN_W-1:0]  LEN_ONE   = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [DATA_W-1:0] DATA_ZERO = {DATA_W{1'b0}};
  localparam logic [ADDR_W-1:0] ADDR_ZERO = {ADDR_W{1'b0}};

  // A zero or oversized length means "largest legal burst".
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    logic [LEN_W-1:0] res;
    if ((len == LEN_ZERO) || (len > MAX_LEN_V)) begin
      res = MAX_LEN_V;
    end else begin
      res = len;
    end
    return res;
  endfunction

  state_t            state_q, state_d;
  logic              gnt0_q, gnt0_d;
  logic              gnt1_q, gnt1_d;
  logic              wr_req_q, wr_req_d;
  logic              rd_req_q, rd_req_d;
  logic              done0_q, done0_d;
  logic              done1_q, done1_d;
  logic              err_q, err_d;
  logic              wr_q, wr_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  len_q, len_d;
  logic              rr_last_q, rr_last_d;
  logic [LEN_W-1:0]  cnt_q, cnt_d;

  logic              grant_any_s;
  logic              grant_sel_s;
  logic              req_wr_s;
  logic [ADDR_W-1:0] req_addr_s;
  logic [LEN_W-1:0]  req_len_s;
  logic              ack_v_s;
  logic              last_word_s;

`ifdef ARB_TIMEOUT_EN
  localparam int             WD_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
  localparam logic [WD_W-1:0] WD_ONE  = {{(WD_W-1){1'b0}}, 1'b1};
  logic [WD_W-1:0] wd_q, wd_d;
`else
  logic unused_timeout_s;
  assign unused_timeout_s = (TIMEOUT_CYCLES > 0);
`endif

  // Tie goes to the client that did not win last; a lone requester always wins.
  always_comb begin
    grant_any_s = c0_req | c1_req;
    if (c0_req && c1_req) begin
      grant_sel_s = ~rr_last_q;
    end else begin
      grant_sel_s = c1_req;
    end
  end

  // Burst descriptor of the client about to be granted.
  always_comb begin
    if (grant_sel_s) begin
      req_wr_s   = c1_wr;
      req_addr_s = c1_addr;
      req_len_s  = clamp_len(c1_len);
    end else begin
      req_wr_s   = c0_wr;
      req_addr_s = c0_addr;
      req_len_s  = clamp_len(c0_len);
    end
  end

  assign ack_v_s     = (state_q == S_XFER) & (wr_q ? sdram_wr_ack : sdram_rd_ack);
  assign last_word_s = (cnt_q == (len_q - LEN_ONE));

  // Next-state and next-output logic for the arbitration FSM.
  always_comb begin
    state_d   = state_q;
    gnt0_d    = gnt0_q;
    gnt1_d    = gnt1_q;
    wr_req_d  = wr_req_q;
    rd_req_d  = rd_req_q;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    err_d     = err_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    len_d     = len_q;
    rr_last_d = rr_last_q;
    cnt_d     = cnt_q;
`ifdef ARB_TIMEOUT_EN
    wd_d      = wd_q;
`endif
    case (state_q)
      S_INIT: begin
        if (sdram_init_done) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_INIT;
        end
      end
      S_IDLE: begin
        if (grant_any_s) begin
          state_d   = S_XFER;
          gnt0_d    = ~grant_sel_s;
          gnt1_d    = grant_sel_s;
          wr_req_d  = req_wr_s;
          rd_req_d  = ~req_wr_s;
          wr_d      = req_wr_s;
          addr_d    = req_addr_s;
          len_d     = req_len_s;
          rr_last_d = grant_sel_s;
          cnt_d     = LEN_ZERO;
`ifdef ARB_TIMEOUT_EN
          wd_d      = {WD_W{1'b0}};
`endif
        end else begin
          state_d = S_IDLE;
        end
      end
      S_XFER: begin
        if (ack_v_s && last_word_s) begin
          state_d  = S_DONE;
          gnt0_d   = 1'b0;
          gnt1_d   = 1'b0;
          wr_req_d = 1'b0;
          rd_req_d = 1'b0;
          done0_d  = gnt0_q;
          done1_d  = gnt1_q;
          cnt_d    = cnt_q + LEN_ONE;
        end else if (ack_v_s) begin
          cnt_d = cnt_q + LEN_ONE;
`ifdef ARB_TIMEOUT_EN
          wd_d  = {WD_W{1'b0}};
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
          // Silent SDRAM: abandon the burst and flag it permanently.
          if (wd_q == WD_LAST) begin
            state_d  = S_DONE;
            gnt0_d   = 1'b0;
            gnt1_d   = 1'b0;
            wr_req_d = 1'b0;
            rd_req_d = 1'b0;
            done0_d  = gnt0_q;
            done1_d  = gnt1_q;
            err_d    = 1'b1;
          end else begin
            wd_d = wd_q + WD_ONE;
          end
`else
          cnt_d = cnt_q;
`endif
        end
      end
      S_DONE: begin
        cnt_d   = LEN_ZERO;
        state_d = S_IDLE;
      end
      default: begin
        state_d  = S_INIT;
        gnt0_d   = 1'b0;
        gnt1_d   = 1'b0;
        wr_req_d = 1'b0;
        rd_req_d = 1'b0;
        cnt_d    = LEN_ZERO;
      end
    endcase
  end

  // State and output registers; reset drops every output immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_INIT;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      wr_req_q  <= 1'b0;
      rd_req_q  <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      err_q     <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= ADDR_ZERO;
      len_q     <= LEN_ZERO;
      rr_last_q <= 1'b1;
      cnt_q     <= LEN_ZERO;
`ifdef ARB_TIMEOUT_EN
      wd_q      <= {WD_W{1'b0}};
`endif
    end else begin
      state_q   <= state_d;
      gnt0_q    <= gnt0_d;
      gnt1_q    <= gnt1_d;
      wr_req_q  <= wr_req_d;
      rd_req_q  <= rd_req_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
      err_q     <= err_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      rr_last_q <= rr_last_d;
      cnt_q     <= cnt_d;
`ifdef ARB_TIMEOUT_EN
      wd_q      <= wd_d;
`endif
    end
  end

  // Write data comes from whichever client currently owns the port.
  always_comb begin
    if (gnt1_q) begin
      sys_data_in = c1_wdata;
    end else if (gnt0_q) begin
      sys_data_in = c0_wdata;
    end else begin
      sys_data_in = DATA_ZERO;
    end
  end

  assign c0_gnt       = gnt0_q;
  assign c1_gnt       = gnt1_q;
  assign c0_wr_ack    = gnt0_q & wr_q & sdram_wr_ack;
  assign c1_wr_ack    = gnt1_q & wr_q & sdram_wr_ack;
  assign c0_rd_ack    = gnt0_q & ~wr_q & sdram_rd_ack;
  assign c1_rd_ack    = gnt1_q & ~wr_q & sdram_rd_ack;
  assign c0_done      = done0_q;
  assign c1_done      = done1_q;
  assign err          = err_q;
  assign sdram_wr_req = wr_req_q;
  assign sdram_rd_req = rd_req_q;
  assign rdata        = rd_req_q ? sys_data_out : DATA_ZERO;
  assign sys_wraddr   = addr_q;
  assign sys_rdaddr   = addr_q;
  assign sdwr_byte    = len_q;
  assign sdrd_byte    = len_q;

endmodule
